// File: rtl/cardinal_pkg.sv
// cardinal_pkg: packet field positions, default width and port indices shared
// by the cardinal ring router and its arbiters.
package cardinal_pkg;
    localparam int DW_DEF  = 64;
    localparam int VC_BIT  = 0;
    localparam int DIR_BIT = 1;
    localparam int HOP_MSB = 8;
    localparam int HOP_LSB = 15;
    localparam int HOP_W   = HOP_LSB - HOP_MSB + 1;
    localparam int P_CW    = 0;
    localparam int P_CCW   = 1;
    localparam int P_PE    = 2;
    localparam int NP      = 3;
endpackage

// File: rtl/cardinal_rr_arb2.sv
// cardinal_rr_arb2: two-requester round-robin arbiter; the priority pointer
// only moves past the winner when a grant is actually issued.
module cardinal_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic r_ptr;  // 0: requester 0 (ring input) has priority
    assign o_gnt[0] = i_en & i_req[0] & (~r_ptr | ~i_req[1]);
    assign o_gnt[1] = i_en & i_req[1] & ( r_ptr | ~i_req[0]);
    always_ff @(posedge clk) begin
        if (reset) r_ptr <= 1'b0;
        else if (|o_gnt) r_ptr <= o_gnt[0];
    end
endmodule

// File: rtl/cardinal_router.sv
// cardinal_router: three-port bidirectional ring router with two virtual
// channels that take turns on a shared polarity bit; one buffer per port per vc.
module cardinal_router
    import cardinal_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cwsi,
    input  logic          ccwsi,
    input  logic          pesi,
    input  logic [0:DW-1] cwdi,
    input  logic [0:DW-1] ccwdi,
    input  logic [0:DW-1] pedi,
    output logic          cwro,
    output logic          ccwro,
    output logic          pero,
    output logic          cwso,
    output logic          ccwso,
    output logic          peso,
    output logic [0:DW-1] cwdo,
    output logic [0:DW-1] ccwdo,
    output logic [0:DW-1] pedo,
    input  logic          cwri,
    input  logic          ccwri,
    input  logic          peri,
    output logic          polarity
);
    logic          r_pol;
    logic [1:0]    r_full [NP];
    logic [0:DW-1] r_buf  [NP][2];
    logic [NP-1:0] r_so;
    logic [0:DW-1] r_do   [NP];
    logic [NP-1:0] w_si, w_ri, w_ev, w_clr, w_wr;
    logic [1:0]    w_hz;
    logic [0:DW-1] w_di   [NP];
    logic [0:DW-1] w_eb   [NP];
    logic [0:DW-1] w_fwd  [2];
    logic [0:DW-1] w_nd   [NP];
    logic [1:0]    w_req  [NP];
    logic [1:0]    w_gnt  [NP];

    assign w_si        = {pesi, ccwsi, cwsi};
    assign w_ri        = {peri, ccwri, cwri};
    assign w_di[P_CW]  = cwdi;
    assign w_di[P_CCW] = ccwdi;
    assign w_di[P_PE]  = pedi;

    // Only the buffer whose vc matches the current polarity may send.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            w_eb[p] = r_buf[p][r_pol];
            w_ev[p] = r_full[p][r_pol];
            w_wr[p] = w_si[p] & ~r_full[p][w_di[p][VC_BIT]];
        end
        for (int p = 0; p < 2; p++) begin
            w_hz[p]  = w_eb[p][HOP_MSB:HOP_LSB] == '0;
            w_fwd[p] = w_eb[p];
            w_fwd[p][HOP_MSB:HOP_LSB] = w_eb[p][HOP_MSB:HOP_LSB] - HOP_W'(1);
        end
    end

    // Request bit 0 is the ring input, bit 1 the other contender.
    assign w_req[P_CW]  = {w_ev[P_PE] & ~w_eb[P_PE][DIR_BIT], w_ev[P_CW] & ~w_hz[P_CW]};
    assign w_req[P_CCW] = {w_ev[P_PE] & w_eb[P_PE][DIR_BIT], w_ev[P_CCW] & ~w_hz[P_CCW]};
    assign w_req[P_PE]  = {w_ev[P_CCW] & w_hz[P_CCW], w_ev[P_CW] & w_hz[P_CW]};

    for (genvar o = 0; o < NP; o++) begin : g_arb
        cardinal_rr_arb2 u_arb (
            .clk   (clk),
            .reset (reset),
            .i_en  (w_ri[o]),
            .i_req (w_req[o]),
            .o_gnt (w_gnt[o])
        );
    end

    assign w_clr[P_CW]  = w_gnt[P_CW][0] | w_gnt[P_PE][0];
    assign w_clr[P_CCW] = w_gnt[P_CCW][0] | w_gnt[P_PE][1];
    assign w_clr[P_PE]  = w_gnt[P_CW][1] | w_gnt[P_CCW][1];
    assign w_nd[P_CW]   = w_gnt[P_CW][0] ? w_fwd[P_CW] : w_eb[P_PE];
    assign w_nd[P_CCW]  = w_gnt[P_CCW][0] ? w_fwd[P_CCW] : w_eb[P_PE];
    assign w_nd[P_PE]   = w_gnt[P_PE][0] ? w_eb[P_CW] : w_eb[P_CCW];

    // A drain hits buffer[polarity] while a legal fill hits the other vc, so set/clear never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pol <= 1'b0;
            r_so  <= '0;
            for (int p = 0; p < NP; p++) begin
                r_full[p] <= 2'b00;
                r_do[p]   <= '0;
            end
        end else begin
            r_pol <= ~r_pol;
            for (int p = 0; p < NP; p++) begin
                r_so[p] <= |w_gnt[p];
                if (|w_gnt[p]) r_do[p] <= w_nd[p];
                if (w_clr[p]) r_full[p][r_pol] <= 1'b0;
                if (w_wr[p]) r_full[p][w_di[p][VC_BIT]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++)
            if (w_wr[p]) r_buf[p][w_di[p][VC_BIT]] <= w_di[p];
    end

    assign polarity              = r_pol;
    assign {pero, ccwro, cwro}   = ~w_ev;
    assign {peso, ccwso, cwso}   = r_so;
    assign cwdo                  = r_do[P_CW];
    assign ccwdo                 = r_do[P_CCW];
    assign pedo                  = r_do[P_PE];
endmodule
